// File: rtl/alu_multicycle.sv
// alu_multicycle: registered execute-stage ALU for the MIPS pipeline.
// Single-cycle ops load the output register on the accept edge. mult, div and divu
// (with a non-zero divisor) run a WIDTH-cycle shift-add or restoring-divide loop on
// operand magnitudes. The sign is applied on the final iteration.
// A valid/ready handshake on both sides lets hazard logic stall on a busy MDU.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         select,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   hi,
    output logic               zero,
    output logic               overflow,
    output logic               div_zero,
    output logic               busy
);

    localparam int W2 = 2 * WIDTH;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULT = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_SRLV = 4'b0110;
    localparam logic [3:0] OP_SRAV = 4'b0111;
    localparam logic [3:0] OP_SLLV = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_DIV  = 4'b1110;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    // MUL: {partial product high, remaining multiplier}. DIV: {partial remainder, dividend/quotient}.
    logic [W2-1:0]      work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic               neg_lo_q, neg_lo_d; // negate product / quotient at the end
    logic               neg_hi_q, neg_hi_d; // negate remainder at the end
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;
    logic               div_zero_q, div_zero_d;

    // Magnitude of a value; signed MIN maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? -x : x;
    endfunction

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [SHAMT_W-1:0]      bsh;
    logic [WIDTH-1:0]        sum, diff;
    logic                    accept, is_div, last_iter;

    assign a_s       = a;
    assign b_s       = b;
    assign bsh       = b[SHAMT_W-1:0];
    assign sum       = a + b;
    assign diff      = a - b;
    assign is_div    = (select == OP_DIV) || (select == OP_DIVU);
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_q == SHAMT_W'(WIDTH - 1));

    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_ovf, sc_dz;

    // Single-cycle result, hi and flags for the op currently presented.
    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        case (select)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (a[WIDTH-1] == ~b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_AND:  sc_res = a & b;
            OP_SRLV: sc_res = a >> bsh;
            OP_SRAV: sc_res = a_s >>> bsh;
            OP_SLLV: sc_res = a << bsh;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_DIV, OP_DIVU: begin
                // Only reaches the output when b == 0; non-zero divisors go iterative.
                sc_res = '1;
                sc_hi  = a;
                sc_dz  = 1'b1;
            end
            default: sc_res = '0;
        endcase
    end

    logic [WIDTH:0]   mul_sum, div_sh, div_sub;
    logic [W2-1:0]    mul_next, mul_fin, div_next;
    logic             div_ge;
    logic [WIDTH-1:0] quo_fin, rem_fin;

    // One shift-add multiply step and one restoring-divide step, plus final sign fix-up.
    always_comb begin
        mul_sum  = {1'b0, work_q[W2-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
        mul_fin  = neg_lo_q ? -mul_next : mul_next;
        div_sh   = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opnd_q});
        div_sub  = div_sh - {1'b0, opnd_q};
        div_next = {(div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
        quo_fin  = neg_lo_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        rem_fin  = neg_hi_q ? -div_next[W2-1:WIDTH] : div_next[W2-1:WIDTH];
    end

    // FSM next state, MDU iteration and output-register loading.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        opnd_d      = opnd_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        result_d    = result_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        div_zero_d  = div_zero_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (select == OP_MULT) begin
                        state_d  = ST_MUL;
                        cnt_d    = '0;
                        opnd_d   = mag(a, 1'b1);
                        work_d   = {{WIDTH{1'b0}}, mag(b, 1'b1)};
                        neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_hi_d = 1'b0;
                    end else if (is_div && (b != '0)) begin
                        state_d  = ST_DIV;
                        cnt_d    = '0;
                        opnd_d   = mag(b, select == OP_DIV);
                        work_d   = {{WIDTH{1'b0}}, mag(a, select == OP_DIV)};
                        neg_lo_d = (select == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d = (select == OP_DIV) && a[WIDTH-1];
                    end else begin
                        result_d    = sc_res;
                        hi_d        = sc_hi;
                        zero_d      = (sc_res == '0);
                        overflow_d  = sc_ovf;
                        div_zero_d  = sc_dz;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q + SHAMT_W'(1);
                if (last_iter) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    result_d    = mul_fin[WIDTH-1:0];
                    hi_d        = mul_fin[W2-1:WIDTH];
                    zero_d      = (mul_fin[WIDTH-1:0] == '0);
                    overflow_d  = 1'b0;
                    div_zero_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            ST_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q + SHAMT_W'(1);
                if (last_iter) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    result_d    = quo_fin;
                    hi_d        = rem_fin;
                    zero_d      = (quo_fin == '0);
                    overflow_d  = 1'b0;
                    div_zero_d  = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any iteration and clears every output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            opnd_q      <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            opnd_q      <= opnd_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
